// File: rtl/icache_resp.sv
// icache_resp: direct-mapped, read-only instruction cache with a two-state
// refill FSM (IDLE/FETCH). Hits return data combinationally (zero latency);
// a miss stalls the fetch stage until the refilled line has been written.
// Optional macro ICACHE_PERF_CNT_EN adds saturating hit/miss counters;
// without it hit_cnt/miss_cnt are constant 0 and no counter flops exist.
module icache_resp #(
    parameter int IDX_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          proc_read,
    input  logic          proc_write,
    input  logic [29:0]   proc_addr,
    input  logic [31:0]   proc_wdata,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [27:0]   mem_addr,
    output logic [127:0]  mem_wdata,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
);
    localparam int TAG_W = 28 - IDX_W;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state, state_nxt;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_arr  [LINES];
    logic [127:0]        data_arr [LINES];

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [1:0]          req_off;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [127:0]        line;
    logic                hit;
    logic                start;
    logic                fill;

    // Write port of the cache is unused: writes never touch the arrays.
    logic unused_write;
    assign unused_write = ^{proc_write, proc_wdata};

    assign req_tag  = proc_addr[29:2+IDX_W];
    assign req_idx  = proc_addr[1+IDX_W:2];
    assign req_off  = proc_addr[1:0];
    // Refill target comes from the latched line address so that address
    // changes during FETCH cannot redirect the write.
    assign fill_idx = mem_addr[IDX_W-1:0];
    assign fill_tag = mem_addr[27:IDX_W];

    assign line       = data_arr[req_idx];
    assign proc_rdata = line[{req_off, 5'b0} +: 32];
    assign hit        = proc_read && (state == IDLE) && valid[req_idx]
                        && (tag_arr[req_idx] == req_tag);

    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    // Next-state and handshake outputs; a refill always runs to completion.
    always_comb begin
        state_nxt  = state;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        start      = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    start      = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                mem_read   = 1'b1;
                proc_stall = 1'b1;
                if (mem_ready) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, valid bits and the latched refill address (reset-cleared).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (start) mem_addr <= proc_addr[29:2];
            if (fill)  valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating performance counters: hit cycles and IDLE->FETCH transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && hit_cnt != 32'hFFFF_FFFF)    hit_cnt  <= hit_cnt + 32'd1;
            if (start && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Scoreboard bench for icache_resp: expected instruction words are queued as
// reads are issued and popped when the cache returns an unstalled result.
// A small memory model supplies refill lines with a chosen latency.
module tb_icache_resp;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          proc_read, proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata;
    logic [31:0]   proc_rdata;
    logic          proc_stall;
    logic          mem_read, mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic [31:0]   hit_cnt, miss_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    icache_resp #(.IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: line 1 holds the reference pattern, others are derived.
    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        if (la == 28'h1) l = 128'h0000_0013_0000_0033_0000_0063_0000_0093;
        else for (int k = 0; k < 4; k++) l[32*k +: 32] = {4'(k + 5), la};
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [29:0] a);
        logic [127:0] l;
        l = line_of(a[29:2]);
        return l[{a[1:0], 5'b0} +: 32];
    endfunction

    // One read: counts stall cycles, serves the refill after `lat` FETCH
    // cycles, then checks the returned word against the scoreboard.
    task automatic read_access(input logic [29:0] a, input int lat, input int exp_stalls);
        int stalls = 0;
        int fcyc = 0;
        bit done = 0;
        logic [31:0] e;
        proc_read = 1'b1;
        proc_addr = a;
        exp_q.push_back(word_of(a));
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!proc_stall) begin
                e = exp_q.pop_front();
                chk("rdata", {96'b0, proc_rdata}, {96'b0, e});
                chk("stalls", 128'(stalls), 128'(exp_stalls));
                chk("no_mem_read_on_hit", {127'b0, mem_read}, 128'b0);
                done = 1;
            end else begin
                stalls++;
                if (mem_read) begin
                    fcyc++;
                    if (fcyc == 1) chk("mem_addr", {100'b0, mem_addr}, {100'b0, a[29:2]});
                    mem_rdata = line_of(a[29:2]);
                    mem_ready = (fcyc == lat);
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        if (!done) chk("read_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", {127'b0, mem_read}, 128'b0);
        chk("rst_mem_addr", {100'b0, mem_addr}, 128'b0);
        chk("rst_stall",    {127'b0, proc_stall}, 128'b0);
        chk("rst_hit_cnt",  {96'b0, hit_cnt}, 128'b0);
        chk("rst_miss_cnt", {96'b0, miss_cnt}, 128'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // cold miss (4 stall cycles) then offset sweep on the same line
        read_access(30'h0000_0004, 3, 4);
        read_access(30'h0000_0005, 1, 0);
        read_access(30'h0000_0006, 1, 0);
        read_access(30'h0000_0007, 1, 0);
        proc_read = 1'b0;
        chk("sweep_word3", {96'b0, word_of(30'h7)}, {96'b0, 32'h0000_0013});
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_cnt",  {96'b0, hit_cnt},  128'd4);
        chk("miss_cnt", {96'b0, miss_cnt}, 128'd1);
`else
        chk("hit_cnt",  {96'b0, hit_cnt},  128'd0);
        chk("miss_cnt", {96'b0, miss_cnt}, 128'd0);
`endif

        // write-only request to a missing line: no stall, no refill
        proc_write = 1'b1; proc_addr = 30'h0000_0100;
        @(negedge clk);
        chk("write_stall", {127'b0, proc_stall}, 128'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("write_mem_read", {127'b0, mem_read}, 128'b0);
        @(posedge clk); #1;

        // read+write together behaves as a read; then conflict eviction
        read_access(30'h0000_0024, 2, 3);
        proc_write = 1'b0;
        read_access(30'h0000_0004, 1, 2);

        // address change mid-FETCH
        proc_read = 1'b1; proc_addr = 30'h0000_0008;
        @(negedge clk);
        chk("chg_req_stall", {127'b0, proc_stall}, 128'b1);
        @(posedge clk); #1;
        proc_addr = 30'h0000_0040;
        @(negedge clk);
        chk("chg_mem_read", {127'b0, mem_read}, 128'b1);
        chk("chg_mem_addr", {100'b0, mem_addr}, 128'h2);
        mem_rdata = line_of(28'h2); mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("chg_new_miss_stall", {127'b0, proc_stall}, 128'b1);
        chk("chg_idle_mem_read",  {127'b0, mem_read}, 128'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("chg_new_mem_addr", {100'b0, mem_addr}, 128'h10);
        mem_rdata = line_of(28'h10); mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        read_access(30'h0000_0040, 1, 0);
        read_access(30'h0000_0008, 1, 0);

        // reset mid-FETCH abandons the refill
        proc_addr = 30'h0000_0080;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rf_mem_read", {127'b0, mem_read}, 128'b1);
        #1 rst_n = 1'b0; proc_read = 1'b0;
        #1;
        chk("rf_rst_mem_read", {127'b0, mem_read}, 128'b0);
        chk("rf_rst_mem_addr", {100'b0, mem_addr}, 128'b0);
        chk("rf_rst_stall",    {127'b0, proc_stall}, 128'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rdata = line_of(28'h20); mem_ready = 1'b1;
        @(negedge clk);
        chk("rf_late_ready_mem_read", {127'b0, mem_read}, 128'b0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        read_access(30'h0000_0080, 2, 3);
        read_access(30'h0000_0004, 1, 2);
        proc_read = 1'b0;
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
